// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - 8N1 serial receiver assembling BYTES-byte frames into one word
module uart_frame_rx #(
    parameter int BAUD_DIV     = 5208,
    parameter int BYTES        = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [8*BYTES-1:0]   Data,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [7:0]           rx_byte,
    output logic [2:0]           byte_cnt
);

    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(TIMEOUT_BITS * BAUD_DIV + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LIMIT    = IW'(TIMEOUT_BITS * BAUD_DIV);
    localparam logic [IW-1:0] LIMIT_M1 = IW'(TIMEOUT_BITS * BAUD_DIV - 1);
    localparam logic [2:0]    LAST     = 3'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [W-1:0]  frame_q, frame_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [W-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    rx_byte_q, rx_byte_d;

    logic          fall;
    logic [W-1:0]  word;

    // Two-flop synchronizer plus one-cycle history for start-edge detection
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            frame_q    <= '0;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            frame_q    <= frame_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    // Next-state logic: bit timing, byte acceptance, frame completion and timeout
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_d    = frame_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = '0;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rx_byte_d  = rx_byte_q;

        // Frame buffer with the just-received byte dropped into its slot
        word = frame_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == 3'(i)) begin
                word[8*i +: 8] = shift_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (fall) begin
                    // A start edge beats a simultaneous timeout expiry
                    state_d = S_START;
                end else if (byte_cnt_q != 3'd0) begin
                    if (idle_q == LIMIT_M1) begin
                        err_d      = 1'b1;
                        byte_cnt_d = '0;
                        idle_d     = LIMIT;
                    end else if (idle_q != LIMIT) begin
                        idle_d = idle_q + IW'(1);
                    end else begin
                        idle_d = LIMIT;
                    end
                end
            end
            S_START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        rx_byte_d = shift_q;
                        frame_d   = word;
                        if (byte_cnt_q == LAST) begin
                            data_d     = word;
                            done_d     = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        err_d      = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = S_WAIT_HIGH;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                // Require a full bit-time of continuous idle before rearming
                if (!rx_s_q) begin
                    baud_d = '0;
                end else if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    assign Data       = data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign rx_byte    = rx_byte_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed and randomized checks of uart_frame_rx against a frame-level model
module tb_uart_frame_rx;

    localparam int BAUD  = 8;
    localparam int TOB   = 20;
    localparam int NBYTE = 5;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [39:0] Data;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  rx_byte;
    logic [2:0]  byte_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    logic [39:0] got_data [0:63];
    int          done_cyc [0:63];

    uart_frame_rx #(
        .BAUD_DIV     (BAUD),
        .BYTES        (NBYTE),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .Data       (Data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .rx_byte    (rx_byte),
        .byte_cnt   (byte_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Pulse monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (frame_done) begin
            if (done_cnt < 64) begin
                got_data[done_cnt] = Data;
                done_cyc[done_cnt] = cyc;
            end
            done_cnt++;
        end
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) begin
            n_assert++;
            n_fail++;
            $error("FAIL pulse_overlap: observed done=1 err=1 required not both");
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge sys_clk) uart_rx = b;
        repeat (BAUD - 1) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        @(negedge sys_clk) uart_rx = 1'b1;
        repeat (n - 1) @(negedge sys_clk);
    endtask

    // Reference: frame word is the little-endian packing of its bytes
    function automatic logic [63:0] pack(input logic [7:0] b [0:4]);
        logic [63:0] w = 0;
        for (int i = 0; i < NBYTE; i++) w = w + (64'(b[i]) << (8 * i));
        return w;
    endfunction

    task automatic send_frame(input logic [7:0] b [0:4]);
        for (int i = 0; i < NBYTE; i++) send_byte(b[i], 1'b1);
    endtask

    task automatic rand_bytes(output logic [7:0] b [0:4]);
        for (int i = 0; i < NBYTE; i++) b[i] = 8'($urandom_range(0, 255));
    endtask

    logic [7:0]  fb [0:4];
    logic [7:0]  fb2 [0:4];
    logic [63:0] exp_word;
    int d0, e0;

    initial begin
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("reset_data", 64'(Data), 64'h0);
        chk("reset_done", 64'(frame_done), 64'h0);
        chk("reset_err", 64'(frame_err), 64'h0);
        chk("reset_rx_byte", 64'(rx_byte), 64'h0);
        chk("reset_byte_cnt", 64'(byte_cnt), 64'h0);
        idle(10);

        // Single frame
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        d0 = done_cnt; e0 = err_cnt;
        send_frame(fb);
        idle(10);
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_data", 64'(Data), 64'h5544332211);
        chk("t1_byte_cnt", 64'(byte_cnt), 64'h0);
        chk("t1_err_pulses", 64'(err_cnt - e0), 64'd0);
        chk("t1_rx_byte", 64'(rx_byte), 64'h55);

        // Glitch rejection
        d0 = done_cnt; e0 = err_cnt;
        @(negedge sys_clk) uart_rx = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk) uart_rx = 1'b1;
        idle(20);
        chk("t2_glitch_done", 64'(done_cnt - d0), 64'd0);
        chk("t2_glitch_err", 64'(err_cnt - e0), 64'd0);
        chk("t2_glitch_data", 64'(Data), 64'h5544332211);
        chk("t2_glitch_byte_cnt", 64'(byte_cnt), 64'h0);
        chk("t2_glitch_rx_byte", 64'(rx_byte), 64'h55);
        fb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_frame(fb);
        idle(10);
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t2_data", 64'(Data), 64'hEEDDCCBBAA);

        // Bad stop bit on the third byte
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h71, 1'b1);
        send_byte(8'h72, 1'b1);
        send_byte(8'h73, 1'b0);
        idle(BAUD);
        chk("t3_err_pulses", 64'(err_cnt - e0), 64'd1);
        chk("t3_done_pulses", 64'(done_cnt - d0), 64'd0);
        chk("t3_data_held", 64'(Data), 64'hEEDDCCBBAA);
        chk("t3_byte_cnt", 64'(byte_cnt), 64'h0);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(fb);
        idle(10);
        chk("t3_done_after", 64'(done_cnt - d0), 64'd1);
        chk("t3_data", 64'(Data), pack(fb));

        // Partial-frame timeout
        d0 = done_cnt; e0 = err_cnt;
        rand_bytes(fb);
        send_byte(fb[0], 1'b1);
        send_byte(fb[1], 1'b1);
        chk("t4_byte_cnt_two", 64'(byte_cnt), 64'd2);
        chk("t4_rx_byte", 64'(rx_byte), 64'(fb[1]));
        idle(100);
        chk("t4_no_early_err", 64'(err_cnt - e0), 64'd0);
        idle(100);
        chk("t4_err_pulses", 64'(err_cnt - e0), 64'd1);
        chk("t4_byte_cnt_zero", 64'(byte_cnt), 64'h0);
        chk("t4_data_held", 64'(Data), 64'h0504030201);
        rand_bytes(fb);
        send_frame(fb);
        idle(10);
        chk("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t4_data", 64'(Data), pack(fb));

        // Back-to-back frames, no idle anywhere
        d0 = done_cnt; e0 = err_cnt;
        rand_bytes(fb);
        rand_bytes(fb2);
        send_frame(fb);
        send_frame(fb2);
        idle(10);
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'd2);
        chk("t5_err_pulses", 64'(err_cnt - e0), 64'd0);
        if (done_cnt - d0 == 2 && done_cnt <= 64) begin
            chk("t5_data0", 64'(got_data[d0]), pack(fb));
            chk("t5_data1", 64'(got_data[d0 + 1]), pack(fb2));
            chk("t5_spacing", 64'(done_cyc[d0 + 1] - done_cyc[d0]), 64'd400);
        end
        chk("t5_data_final", 64'(Data), pack(fb2));

        // Reset during the fourth byte's data bits
        rand_bytes(fb);
        send_byte(fb[0], 1'b1);
        send_byte(fb[1], 1'b1);
        send_byte(fb[2], 1'b1);
        send_bit(1'b0);
        send_bit(fb[3][0]);
        send_bit(fb[3][1]);
        @(negedge sys_clk) begin
            rst = 1'b1;
            uart_rx = 1'b1;
        end
        @(negedge sys_clk) rst = 1'b0;
        chk("t6_rst_data", 64'(Data), 64'h0);
        chk("t6_rst_rx_byte", 64'(rx_byte), 64'h0);
        chk("t6_rst_byte_cnt", 64'(byte_cnt), 64'h0);
        chk("t6_rst_done", 64'(frame_done), 64'h0);
        chk("t6_rst_err", 64'(frame_err), 64'h0);
        d0 = done_cnt; e0 = err_cnt;
        idle(20);
        rand_bytes(fb);
        send_frame(fb);
        idle(10);
        chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t6_err_pulses", 64'(err_cnt - e0), 64'd0);
        exp_word = pack(fb);
        chk("t6_data", 64'(Data), exp_word);
        chk("t6_byte_cnt", 64'(byte_cnt), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
